// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the iterative multiply/divide unit.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRL    = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_BEQ    = 4'b1000;
    localparam logic [3:0] OP_SLT    = 4'b1100;
    localparam logic [3:0] OP_SLTU   = 4'b1101;
    localparam logic [3:0] OP_PASS_B = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_JAL    = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 magnitude engine: shift-add multiply or restoring divide, one step per cycle.
// hi holds the partial product / remainder, lo the multiplier / quotient bits.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic             last_o,
    output logic             b_zero_o,
    output logic [WIDTH-1:0] hi_d_o,
    output logic [WIDTH-1:0] lo_d_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum, shifted, diff;

    always_comb begin
        sum     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        hi_d_o  = sum[WIDTH:1];
        lo_d_o  = {sum[0], lo_q[WIDTH-1:1]};
        if (is_div_i) begin
            // A non-negative trial difference means the divisor fits: keep it, quotient bit 1.
            if (!diff[WIDTH]) begin
                hi_d_o = diff[WIDTH-1:0];
                lo_d_o = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d_o = shifted[WIDTH-1:0];
                lo_d_o = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= a_mag_i;
            b_q   <= b_mag_i;
            cnt_q <= '0;
        end else if (step_i) begin
            hi_q  <= hi_d_o;
            lo_q  <= lo_d_o;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_o   = (cnt_q == CW'(WIDTH - 1));
    assign b_zero_o = (b_q == '0);

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode plus the sequencing FSM and sign handling for the M-extension unit.
// Handshake: an M-op is accepted in IDLE when valid_i & ~flush; stall holds the pipeline until DONE.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             IsRType,
    input  logic             valid_i,
    input  logic             flush,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [OP_W-1:0]  Operation,
    output logic             mdu_sel,
    output logic             stall,
    output logic [WIDTH-1:0] mdu_result,
    output logic             mdu_done,
    output mdu_state_t       mdu_state_o
);
    mdu_state_t       state_q, state_d;
    logic [3:0]       op_c;
    logic             mop_c, accept_c, step_c, finish_c, stall_c;
    logic             a_signed_c, b_signed_c, sa_c, sb_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c, hi_d, lo_d, res_c;
    logic [2*WIDTH-1:0] prod_c;
    logic             sa_q, sb_q, done_q, last, b_zero;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] result_q;

    assign mop_c = (ALUOp == ALUOP_ARITH) && IsRType && (Funct7 == F7_MULDIV);

    always_comb begin
        op_c = OP_ADD;
        unique case (ALUOp)
            ALUOP_MEM:    op_c = OP_ADD;
            ALUOP_BRANCH: op_c = OP_BEQ;
            ALUOP_JAL:    op_c = OP_PASS_B;
            default: begin
                if (!mop_c) begin
                    unique case (Funct3)
                        3'b000:  op_c = (IsRType && Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                        3'b001:  op_c = OP_SLL;
                        3'b010:  op_c = OP_SLT;
                        3'b011:  op_c = OP_SLTU;
                        3'b100:  op_c = OP_XOR;
                        // Shift immediates carry the arithmetic flag in the same bits, so IsRType is ignored.
                        3'b101:  op_c = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                        3'b110:  op_c = OP_OR;
                        default: op_c = OP_AND;
                    endcase
                end
            end
        endcase
    end

    assign Operation = OP_W'(op_c);
    assign mdu_sel   = mop_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_i && mop_c && !flush) state_d = BUSY;
            BUSY:    if (flush) state_d = IDLE;
                     else if (last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept_c = (state_q == IDLE) && valid_i && mop_c && !flush;
        step_c   = (state_q == BUSY) && !flush;
        finish_c = step_c && last;
        stall_c  = !reset && (accept_c || state_q == BUSY);
    end

    assign a_signed_c = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    assign b_signed_c = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    assign sa_c    = a_signed_c && SrcA[WIDTH-1];
    assign sb_c    = b_signed_c && SrcB[WIDTH-1];
    assign a_mag_c = sa_c ? -SrcA : SrcA;
    assign b_mag_c = sb_c ? -SrcB : SrcB;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept_c),
        .step_i   (step_c),
        .is_div_i (f3_q[2]),
        .a_mag_i  (a_mag_c),
        .b_mag_i  (b_mag_c),
        .last_o   (last),
        .b_zero_o (b_zero),
        .hi_d_o   (hi_d),
        .lo_d_o   (lo_d)
    );

    // Sign fix-up on the final iteration's outputs; a zero divisor keeps the all-ones quotient.
    always_comb begin
        prod_c = (sa_q ^ sb_q) ? -{hi_d, lo_d} : {hi_d, lo_d};
        unique case (f3_q)
            F3_MUL:                      res_c = prod_c[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_c = prod_c[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:             res_c = ((sa_q ^ sb_q) && !b_zero) ? -lo_d : lo_d;
            default:                     res_c = sa_q ? -hi_d : hi_d;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            f3_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= finish_c;
            if (accept_c) begin
                sa_q <= sa_c;
                sb_q <= sb_c;
                f3_q <= Funct3;
            end
            if (finish_c) result_q <= res_c;
        end
    end

    assign stall       = stall_c;
    assign mdu_done    = done_q;
    assign mdu_result  = result_q;
    assign mdu_state_o = state_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Randomized bench for alu_ctrl_mdu: decode table, M-op results against an arithmetic model, aborts.
module tb_alu_ctrl_mdu;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   ALUOp;
    logic [6:0]   Funct7;
    logic [2:0]   Funct3;
    logic         IsRType, valid_i, flush;
    logic [W-1:0] SrcA, SrcB;
    logic [3:0]   Operation;
    logic         mdu_sel, stall, mdu_done;
    logic [W-1:0] mdu_result;
    mdu_state_t   mdu_state_o;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res = '0;

    alu_ctrl_mdu #(.WIDTH(W), .OP_W(4)) dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .IsRType(IsRType), .valid_i(valid_i), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .mdu_sel(mdu_sel), .stall(stall), .mdu_result(mdu_result),
        .mdu_done(mdu_done), .mdu_state_o(mdu_state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mdu_done) done_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected M-extension result from plain 64-bit arithmetic.
    function automatic logic [W-1:0] ref_mdu(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        logic            ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return '0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected ALU operation from the instruction fields; mdu reports an M-extension op.
    function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic isr, output logic mdu);
        logic [3:0] arith [8];
        arith = '{4'b0010, 4'b0100, 4'b1100, 4'b1101, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        mdu = (aluop == 2'b10) && isr && (f7 == 7'b0000001);
        if (aluop == 2'b00 || mdu) return 4'b0010;
        if (aluop == 2'b01) return 4'b1000;
        if (aluop == 2'b11) return 4'b1111;
        if (f3 == 3'b000 && isr && f7 == 7'b0100000) return 4'b0110;
        if (f3 == 3'b101 && f7 == 7'b0100000) return 4'b0111;
        return arith[f3];
    endfunction

    task automatic drive_mop(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUOp = 2'b10; IsRType = 1'b1; Funct7 = 7'b0000001; Funct3 = f3;
        SrcA = a; SrcB = b; valid_i = 1'b1; flush = 1'b0;
    endtask

    // Called at posedge+1 of the issue cycle; returns at posedge+2 of the DONE cycle, op still held.
    task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc = 0;
        int stall_lo = 0;
        bit seen = 0;
        logic [W-1:0] exp;
        exp_q.push_back(ref_mdu(f3, a, b));
        drive_mop(f3, a, b);
        #1;
        check_eq("accept_stall", stall, 1);
        check_eq("accept_mdu_sel", mdu_sel, 1);
        check_eq("accept_op_add", Operation, 4'b0010);
        while (!seen && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
            if (mdu_done) seen = 1;
            else if (!stall) stall_lo++;
        end
        exp = exp_q.pop_front();
        if (!seen) begin
            check_eq("done_timeout", 0, 1);
        end else begin
            check_eq("latency", cyc, W + 1);
            check_eq("stall_gap", stall_lo, 0);
            check_eq("done_stall_low", stall, 0);
            check_eq($sformatf("result_f3_%0d", f3), mdu_result, exp);
            last_res = exp;
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        valid_i = 1'b0; flush = 1'b0;
        #1;
        check_eq("after_done_idle", mdu_state_o, IDLE);
        check_eq("after_done_stall", stall, 0);
        check_eq("result_hold", mdu_result, last_res);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corner [4];
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return $urandom();
    endfunction

    initial begin
        logic [6:0] f7_pick [4];
        logic       mdu_exp;
        logic [3:0] op_exp;
        int         d0;
        f7_pick = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b1010101};

        // Reset with an M-op presented: nothing may start and stall stays low.
        reset = 1'b1;
        drive_mop(F3_MUL, 32'd3, 32'd4);
        #2;
        check_eq("rst_state", mdu_state_o, IDLE);
        check_eq("rst_done", mdu_done, 0);
        check_eq("rst_result", mdu_result, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_mdu_sel_comb", mdu_sel, 1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; valid_i = 1'b0;

        // Decode table, no instruction valid.
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            ALUOp = 2'($urandom_range(0, 3)); Funct3 = 3'($urandom_range(0, 7));
            Funct7 = f7_pick[$urandom_range(0, 3)]; IsRType = 1'($urandom_range(0, 1));
            valid_i = 1'b0;
            #1;
            op_exp = ref_op(ALUOp, Funct3, Funct7, IsRType, mdu_exp);
            check_eq($sformatf("dec_op_%b_%b_%b_%b", ALUOp, Funct3, Funct7, IsRType), Operation, op_exp);
            check_eq("dec_mdu_sel", mdu_sel, mdu_exp);
            check_eq("dec_stall", stall, 0);
        end

        // SUB versus ADD with the alternate Funct7, instruction valid.
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            ALUOp = 2'b10; Funct3 = 3'b000; Funct7 = 7'b0100000; IsRType = 1'(1 - r); valid_i = 1'b1;
            #1;
            check_eq($sformatf("sub_add_op_r%0d", 1 - r), Operation, (r == 0) ? 4'b0110 : 4'b0010);
            check_eq("sub_add_mdu_sel", mdu_sel, 0);
            check_eq("sub_add_stall", stall, 0);
        end

        // Directed M-op results.
        @(posedge clk); #1; run_op(F3_MUL,   32'd7, 32'hFFFF_FFFD);  go_idle();
        @(posedge clk); #1; run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); go_idle();
        @(posedge clk); #1; run_op(F3_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF); go_idle();
        @(posedge clk); #1; run_op(F3_DIV,   32'd5, 32'd0); go_idle();
        @(posedge clk); #1; run_op(F3_REM,   32'd5, 32'd0); go_idle();
        @(posedge clk); #1; run_op(F3_DIV,   32'h8000_0000, 32'hFFFF_FFFF); go_idle();
        @(posedge clk); #1; run_op(F3_REM,   32'h8000_0000, 32'hFFFF_FFFF); go_idle();
        @(posedge clk); #1; run_op(F3_DIVU,  32'd100, 32'd7); go_idle();
        @(posedge clk); #1; run_op(F3_REMU,  32'd100, 32'd7); go_idle();
        @(posedge clk); #1; run_op(F3_DIV,   32'hFFFF_FFF9, 32'd0); go_idle();

        // Back-to-back DIV then MUL; the second is accepted right after DONE.
        d0 = done_cnt;
        @(posedge clk); #1; run_op(F3_DIV, 32'hFFFF_FF9C, 32'd7);
        @(posedge clk); #1; run_op(F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        go_idle();
        repeat (5) @(posedge clk);
        #2;
        check_eq("b2b_done_pulses", done_cnt - d0, 2);

        // Randomized M-ops.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            go_idle();
        end

        // Flush at cycle 5.
        d0 = done_cnt;
        @(posedge clk); #1;
        drive_mop(F3_DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1; flush = 1'b1;
        #1; check_eq("flush_c5_stall", stall, 1);
        @(posedge clk); #1; flush = 1'b0; valid_i = 1'b0;
        #1;
        check_eq("flush_c6_stall", stall, 0);
        check_eq("flush_c6_state", mdu_state_o, IDLE);
        repeat (40) @(posedge clk);
        #2;
        check_eq("flush_no_done", done_cnt - d0, 0);
        check_eq("flush_result_hold", mdu_result, last_res);

        // Reset at cycle 10.
        d0 = done_cnt;
        @(posedge clk); #1;
        drive_mop(F3_MUL, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        #1;
        check_eq("rst_mid_state", mdu_state_o, IDLE);
        check_eq("rst_mid_done", mdu_done, 0);
        check_eq("rst_mid_result", mdu_result, 0);
        check_eq("rst_mid_stall", stall, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; valid_i = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check_eq("rst_no_done", done_cnt - d0, 0);
        last_res = '0;
        @(posedge clk); #1; run_op(F3_MUL, $urandom(), $urandom()); go_idle();

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; SHALL be a power of two, at least 8.
REQ-002 Parameter OP_W, default 4: width of Operation.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ALUOp  input  2  00 load/store/AUIPC, 01 branch, 10 R/I arithmetic, 11 JAL/LUI.
REQ-006 Funct7  input  7  instruction bits 31:25.
REQ-007 Funct3  input  3  instruction bits 14:12.
REQ-008 IsRType  input  1  1 = R-type; Funct7 qualifies the decode only when IsRType=1, except for shifts.
REQ-009 valid_i  input  1  the EX-stage instruction is valid.
REQ-010 flush  input  1  abort any multiply/divide in flight.
REQ-011 SrcA, SrcB  input  WIDTH  operands.
REQ-012 Operation  output  OP_W  ALU operation select.
REQ-013 mdu_sel  output  1  the decoded instruction is an M-extension op; the datapath takes mdu_result.
REQ-014 stall  output  1  freeze the pipeline; SrcA, SrcB and the decode inputs SHALL be held stable while it is high.
REQ-015 mdu_result  output  WIDTH  multiply/divide result; valid while mdu_done=1.
REQ-016 mdu_done  output  1  one-cycle pulse marking mdu_result valid.

Function
REQ-017 Operation and mdu_sel SHALL be combinational, with zero latency.
- Operation encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, BEQ-compare 1000, SLT 1100, SLTU 1101, PASS_B 1111.
REQ-018 Decode by ALUOp:
- 00 -> ADD.
- 01 -> compare.
- 11 -> PASS_B.
- 10 -> by Funct3: 000 ADD, or SUB only when IsRType=1 and Funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when Funct7=0100000 (regardless of IsRType); 110 OR; 111 AND.
REQ-019 M-op: ALUOp=10, IsRType=1 and Funct7=0000001.
- mdu_sel=1 and Operation=ADD.
- Funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000 through 111).
REQ-020 FSM states and transitions:
- IDLE -> BUSY on valid_i & M-op & ~flush, capturing operand magnitudes, operand signs and Funct3.
- BUSY: one radix-2 iteration per cycle, shift-add for multiply, restoring for divide; -> DONE after exactly WIDTH iterations.
- DONE -> IDLE unconditionally.
REQ-021 stall SHALL equal (IDLE & valid_i & M-op & ~flush) | BUSY.
- stall is high for WIDTH+1 cycles from acceptance.
- mdu_done=1 in the next cycle, the DONE cycle, in which stall=0.
REQ-022 The held M-op seen again in DONE SHALL NOT restart the unit.
- A new M-op presented in the cycle after DONE SHALL be accepted.
REQ-023 Signedness:
- MULH treats both operands as signed.
- MULHSU treats SrcA as signed and SrcB as unsigned.
- MULHU, DIVU and REMU treat operands as unsigned.
- The sign correction SHALL be applied when entering DONE.
REQ-024 Result selection:
- MUL returns the low WIDTH bits of the 2*WIDTH product.
- MULH, MULHSU and MULHU return the high WIDTH bits.
REQ-025 Divide by zero: quotient all ones; remainder = SrcA.
REQ-026 Signed overflow (most-negative / -1): quotient = most-negative value; remainder = 0.
REQ-027 The special cases in REQ-025 and REQ-026 SHALL keep the fixed latency.
REQ-028 flush in BUSY SHALL return the FSM to IDLE on the next edge.
- mdu_done SHALL NOT pulse for the aborted operation.
- stall SHALL drop in the cycle after flush.
REQ-029 mdu_result SHALL hold its last value outside DONE.

Reset
REQ-030 While reset=1 the registered outputs SHALL be:
- FSM state IDLE.
- iteration counter 0.
- mdu_result 0.
- mdu_done 0.
- stall 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no done pulse.
- Operation and mdu_sel remain combinational during reset.

Structure
REQ-032 Package alu_ctrl_pkg SHALL hold:
- the Operation encodings;
- the ALUOp codes;
- the Funct7 constants 0000000, 0100000 and 0000001;
- the M-op Funct3 codes;
- the mdu_state_t enum (IDLE, BUSY, DONE).
REQ-033 Sub-modules:
- The iterative datapath SHALL be one sub-module, mdu_iter: accumulator, counter, shift/subtract.
- Decode and FSM SHALL live in alu_ctrl_mdu.

Verification
REQ-034 Decode: ALUOp=10, Funct3=000, Funct7=0100000 -> Operation 0110 with IsRType=1 and 0010 with IsRType=0; in both cases mdu_sel=0 and stall=0.
REQ-035 MUL, WIDTH=32, SrcA=7, SrcB=0xFFFFFFFD, accepted at cycle 0:
- stall high in cycles 0..32.
- mdu_done=1 and mdu_result=0xFFFFFFEB in cycle 33.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000.
REQ-037 Divide corner cases:
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-038 Back-to-back DIV then MUL, both held stable:
- exactly two done pulses.
- second acceptance in the cycle after the first DONE.
REQ-039 Aborts:
- flush at cycle 5 -> stall=0 from cycle 6, no done pulse.
- reset at cycle 10 -> state IDLE, no done pulse, and a new MUL afterwards completes correctly.
